// File: rtl/red_pitaya_asg_bank_sched.sv
// Ping-pong bank scheduler for one ASG channel.
// Software fills the shadow bank (~active_bank_o) and commits it. The scheduler
// swaps banks at the next waveform boundary (swap_evt_i) or immediately when the
// channel is idle, then holds off writes until the read pipeline has settled.
// Optional feature macro: ASG_BANK_SWAP_TMO_EN (forced swap after set_tmo_i cycles
// in ARMED; without it set_tmo_i is ignored and tmo_flag_o is tied low).
// Ports:
//   dac_clk_i, dac_rstn_i      clock, async active-low reset
//   set_rst_i                  synchronous soft reset
//   sw_commit_i, sw_abort_i    software commit / cancel pulses
//   swap_evt_i, ch_idle_i      channel boundary pulse / idle level
//   set_tmo_i                  swap timeout in cycles (0 = off)
//   buf_we_i/addr_i/wdata_i    software write port (shadow-bank relative)
//   buf_we_o/waddr_o/wdata_o   gated, registered RAM write port
//   active_bank_o, pending_o, swap_o, swap_cnt_o, rep_cnt_o, drop_cnt_o, tmo_flag_o
module red_pitaya_asg_bank_sched #(
  parameter int unsigned RSZ = 14
) (
  input  logic           dac_clk_i,
  input  logic           dac_rstn_i,
  input  logic           set_rst_i,
  input  logic           sw_commit_i,
  input  logic           sw_abort_i,
  input  logic           swap_evt_i,
  input  logic           ch_idle_i,
  input  logic [31:0]    set_tmo_i,
  input  logic           buf_we_i,
  input  logic [RSZ-1:0] buf_addr_i,
  input  logic [13:0]    buf_wdata_i,
  output logic           buf_we_o,
  output logic [RSZ:0]   buf_waddr_o,
  output logic [13:0]    buf_wdata_o,
  output logic           active_bank_o,
  output logic           pending_o,
  output logic           swap_o,
  output logic [15:0]    swap_cnt_o,
  output logic [15:0]    rep_cnt_o,
  output logic [15:0]    drop_cnt_o,
  output logic           tmo_flag_o
);
  localparam int unsigned DW = 14;
  localparam int unsigned CW = 16;
  localparam int unsigned SW = 2;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(3);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_SWAP, ST_SETTLE} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic            bank_q, bank_d;
  logic            swap_q, swap_d;
  logic [CW-1:0]   swap_cnt_q, swap_cnt_d;
  logic [CW-1:0]   rep_cnt_q, rep_cnt_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            we_q, we_d;
  logic [RSZ:0]    waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            go_swap;
  logic            accept;

`ifdef ASG_BANK_SWAP_TMO_EN
  logic [31:0]     tmo_cnt_q, tmo_cnt_d;
  logic            tmo_flag_q, tmo_flag_d;
  logic            tmo_hit;
  assign tmo_hit    = (set_tmo_i != 32'd0) && (tmo_cnt_q == set_tmo_i);
  assign tmo_flag_o = tmo_flag_q;
`else
  logic            unused_tmo;
  assign unused_tmo = ^set_tmo_i;
  assign tmo_flag_o = 1'b0;
`endif

  // Writes may only land while the shadow bank is stable and no swap is being requested.
  assign accept = (state_q == ST_IDLE) && !sw_commit_i && !set_rst_i;

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    bank_d     = bank_q;
    swap_d     = 1'b0;
    swap_cnt_d = swap_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    drop_cnt_d = drop_cnt_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    go_swap    = 1'b0;
`ifdef ASG_BANK_SWAP_TMO_EN
    tmo_cnt_d  = tmo_cnt_q;
    tmo_flag_d = tmo_flag_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // A boundary with nothing committed yet is a repeat, even if the commit arrives now.
        if (swap_evt_i && (rep_cnt_q != '1)) rep_cnt_d = rep_cnt_q + CW'(1);
        if (sw_commit_i) state_d = ST_ARMED;
      end
      ST_ARMED: begin
`ifdef ASG_BANK_SWAP_TMO_EN
        tmo_cnt_d = tmo_cnt_q + 32'd1;
`endif
        if (swap_evt_i || ch_idle_i) begin
          go_swap = 1'b1;
        end
`ifdef ASG_BANK_SWAP_TMO_EN
        else if (tmo_hit) begin
          go_swap    = 1'b1;
          tmo_flag_d = 1'b1;
        end
`endif
        else if (sw_abort_i) begin
          state_d = ST_IDLE;
        end
        // Bank toggles with the transition so it is already flipped during SWAP.
        if (go_swap) begin
          state_d    = ST_SWAP;
          bank_d     = ~bank_q;
          swap_d     = 1'b1;
          swap_cnt_d = swap_cnt_q + CW'(1);
        end
      end
      ST_SWAP: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = ST_IDLE;
        else                         settle_d = settle_q + SW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef ASG_BANK_SWAP_TMO_EN
    if (state_d != ST_ARMED) tmo_cnt_d = '0;
`endif

    // Address translation targets the shadow bank as seen in the accepting cycle.
    if (buf_we_i) begin
      if (accept) begin
        we_d    = 1'b1;
        waddr_d = {~bank_q, buf_addr_i};
        wdata_d = buf_wdata_i;
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + CW'(1);
      end
    end

    if (set_rst_i) begin
      state_d    = ST_IDLE;
      settle_d   = '0;
      bank_d     = 1'b0;
      swap_d     = 1'b0;
      swap_cnt_d = '0;
      rep_cnt_d  = '0;
      drop_cnt_d = '0;
      we_d       = 1'b0;
      waddr_d    = '0;
      wdata_d    = '0;
`ifdef ASG_BANK_SWAP_TMO_EN
      tmo_cnt_d  = '0;
      tmo_flag_d = 1'b0;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      bank_q     <= 1'b0;
      swap_q     <= 1'b0;
      swap_cnt_q <= '0;
      rep_cnt_q  <= '0;
      drop_cnt_q <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
`ifdef ASG_BANK_SWAP_TMO_EN
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      bank_q     <= bank_d;
      swap_q     <= swap_d;
      swap_cnt_q <= swap_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
`ifdef ASG_BANK_SWAP_TMO_EN
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
`endif
    end
  end

  assign buf_we_o      = we_q;
  assign buf_waddr_o   = waddr_q;
  assign buf_wdata_o   = wdata_q;
  assign active_bank_o = bank_q;
  assign pending_o     = (state_q == ST_ARMED);
  assign swap_o        = swap_q;
  assign swap_cnt_o    = swap_cnt_q;
  assign rep_cnt_o     = rep_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule
